apbspi_sclk_gen: RTL

APBSPI_SCLK_GEN -- requirements
Module: apbspi_sclk_gen

---
 rtl/apbspi_pkg.sv | 16 +
 rtl/apbspi_tick_cntr.sv | 38 +++
 rtl/apbspi_sclk_gen.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/apbspi_pkg.sv
// rtl/apbspi_pkg.sv - shared types and defaults for the APB SPI clock generator
// Purpose: sequencer state encoding and default widths shared by the SPI
//          clock generator and its half-period counter.
// Ports:   none (package).
package apbspi_pkg;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_MAX_BITS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2
  } state_t;

endpackage

// File: rtl/apbspi_tick_cntr.sv
// rtl/apbspi_tick_cntr.sv - half-period counter with wrap pulse
// Purpose: counts clk cycles while enabled; wrap is high in the cycle the
//          count equals limit, and the count returns to 0 on that edge.
// Ports:   clk, nrst   - clock, async active-low reset
//          clear       - hold count at 0
//          enable      - advance count each cycle
//          limit[W]    - terminal count (half-period minus one)
//          wrap        - combinational half-period elapsed pulse
module apbspi_tick_cntr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         wrap
);

  logic [W-1:0] cnt_q;

  assign wrap = enable && (cnt_q == limit);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      if (wrap) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + W'(1);
      end
    end
  end

endmodule

// File: rtl/apbspi_sclk_gen.sv
// rtl/apbspi_sclk_gen.sv - SPI serial clock and strobe generator
// Purpose: produces a registered SCLK of 2*N edges, each half-period
//          prescaler+1 clk cycles long, followed by one idle half-period,
//          plus MISO sample / MOSI shift strobes and a done pulse.
// Optional: APBSPI_SCLK_ABORT_EN adds the abort input.
// Ports:   clk, nrst        - clock, async active-low reset
//          start            - transfer request (IDLE only)
//          prescaler[CNT_W] - half-period = prescaler+1 clk cycles
//          nbits[BITS_W]    - bits per transfer (0 / >MAX_BITS = MAX_BITS)
//          cpol, cpha       - SPI mode
//          abort            - terminate transfer (optional)
//          sclk             - SPI clock (flop output)
//          sample_stb       - MISO sample point pulse
//          shift_stb        - MOSI shift point pulse
//          busy             - transfer in progress
//          done             - transfer completed pulse
module apbspi_sclk_gen
  import apbspi_pkg::*;
#(
  parameter  int CNT_W    = DEF_CNT_W,
  parameter  int MAX_BITS = DEF_MAX_BITS,
  localparam int BITS_W   = $clog2(MAX_BITS + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [CNT_W-1:0]  prescaler,
  input  logic [BITS_W-1:0] nbits,
  input  logic              cpol,
  input  logic              cpha,
`ifdef APBSPI_SCLK_ABORT_EN
  input  logic              abort,
`endif
  output logic              sclk,
  output logic              sample_stb,
  output logic              shift_stb,
  output logic              busy,
  output logic              done
);

  // One extra bit so 2*MAX_BITS fits without wrapping.
  localparam int EW = BITS_W + 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  presc_q;
  logic [BITS_W-1:0] nbits_q;
  logic              cpol_q, cpha_q;
  logic [EW-1:0]     edge_q;

  logic              tick;
  logic              start_ok;
  logic              abort_hit;
  logic [BITS_W-1:0] nbits_eff;
  logic [EW-1:0]     edge_nxt;
  logic              last_edge;
  logic              lead;

`ifdef APBSPI_SCLK_ABORT_EN
  assign abort_hit = abort && (state_q != IDLE);
  assign start_ok  = start && !abort;
`else
  assign abort_hit = 1'b0;
  assign start_ok  = start;
`endif

  assign nbits_eff = ((nbits == '0) || (nbits > BITS_W'(MAX_BITS))) ? BITS_W'(MAX_BITS) : nbits;
  assign edge_nxt  = edge_q + EW'(1);
  assign last_edge = (edge_nxt == {nbits_q, 1'b0});
  // Odd edge numbers are leading edges.
  assign lead      = edge_nxt[0];
  assign busy      = (state_q != IDLE);

  apbspi_tick_cntr #(
    .W (CNT_W)
  ) u_tick (
    .clk    (clk),
    .nrst   (nrst),
    .clear  (state_q == IDLE),
    .enable (state_q != IDLE),
    .limit  (presc_q),
    .wrap   (tick)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (tick && last_edge) state_d = TAIL;
      TAIL:    if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sclk       <= 1'b0;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
      done       <= 1'b0;
      presc_q    <= '0;
      nbits_q    <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      edge_q     <= '0;
    end else begin
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
      done       <= 1'b0;
      case (state_q)
        IDLE: begin
          sclk <= cpol;
          if (start_ok) begin
            presc_q <= prescaler;
            nbits_q <= nbits_eff;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            edge_q  <= '0;
          end
        end
        RUN: begin
          if (tick) begin
            sclk       <= ~sclk;
            edge_q     <= edge_nxt;
            sample_stb <= cpha_q ? ~lead : lead;
            // No shift after the final trailing edge in mode cpha=0.
            shift_stb  <= cpha_q ? lead : (~lead & ~last_edge);
          end
        end
        TAIL: begin
          if (tick) begin
            sclk <= cpol_q;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
      if (abort_hit) begin
        sclk       <= cpol_q;
        sample_stb <= 1'b0;
        shift_stb  <= 1'b0;
        done       <= 1'b0;
      end
    end
  end

endmodule
